// File: rtl/fpgaboy_pkg.sv
// Shared constants and helpers for the fpgaboy peripheral blocks.
// Holds the debounce defaults, the counter width helper and the counter action type.
package fpgaboy_pkg;

  localparam int DEBOUNCE_DEFAULT_DELAY = 1000000;
  localparam int DEBOUNCE_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    CNT_CLEAR,
    CNT_INC,
    CNT_LOAD,
    CNT_HOLD
  } cnt_action_e;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int r = value - 1; r > 0; r = r >> 1) begin
      w++;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, last-sample register, stable counter, clean level and edge pulses.
// load_o is the combinational "clean changes at the next edge" flag, used by the bank's any_change register.
module debounce_channel
  import fpgaboy_pkg::*;
#(
  parameter int   DELAY       = DEBOUNCE_DEFAULT_DELAY,
  parameter int   SYNC_STAGES = DEBOUNCE_SYNC_STAGES,
  parameter logic INIT_LVL    = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_i,
  input  logic noisy_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic load_o
);

  localparam int             CW   = clog2(DELAY + 1);
  localparam logic [CW-1:0]  TERM = CW'(DELAY - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;
  cnt_action_e            action;

  assign synced = sync_q[SYNC_STAGES-1];

  // A bounce always wins over tick; the counter only advances while last disagrees with clean.
  always_comb begin
    action = CNT_HOLD;
    if (synced != last_q) begin
      action = CNT_CLEAR;
    end else if (last_q == clean_q) begin
      action = CNT_CLEAR;
    end else if (tick_i) begin
      action = (cnt_q == TERM) ? CNT_LOAD : CNT_INC;
    end

    cnt_d   = cnt_q;
    clean_d = clean_q;
    case (action)
      CNT_CLEAR: cnt_d = '0;
      CNT_INC:   cnt_d = cnt_q + CW'(1);
      CNT_LOAD: begin
        cnt_d   = '0;
        clean_d = last_q;
      end
      default: ;
    endcase

    rise_d = (action == CNT_LOAD) &&  last_q;
    fall_d = (action == CNT_LOAD) && !last_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{INIT_LVL}};
      last_q  <= INIT_LVL;
      cnt_q   <= '0;
      clean_q <= INIT_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy_i};
      last_q  <= synced;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign load_o  = (action == CNT_LOAD);

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels with a shared tick and a registered any_change flag.
// any_change is registered from the channels' load flags so it lines up with rise/fall.
module debounce_bank
  import fpgaboy_pkg::*;
#(
  parameter int                  CHANNELS    = 8,
  parameter int                  DELAY       = DEBOUNCE_DEFAULT_DELAY,
  parameter int                  SYNC_STAGES = DEBOUNCE_SYNC_STAGES,
  parameter logic [CHANNELS-1:0] INIT        = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  logic [CHANNELS-1:0] load;
  logic                any_change_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .DELAY       (DELAY),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LVL    (INIT[g])
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .tick_i  (tick),
      .noisy_i (noisy[g]),
      .clean_o (clean[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g]),
      .load_o  (load[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |load;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios with literal expectations plus randomized
// stimulus compared every cycle against a behavioural model (delay line + stable-tick count).
module tb_debounce_bank;

  localparam int         CH   = 4;
  localparam int         DLY  = 4;
  localparam int         SS   = 2;
  localparam logic [3:0] INIT = 4'b0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tick  = 1'b1;
  logic [CH-1:0] noisy = 4'b0101;
  logic [CH-1:0] clean, rise, fall;
  logic          any_change;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_bank #(
    .CHANNELS    (CH),
    .DELAY       (DLY),
    .SYNC_STAGES (SS),
    .INIT        (INIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .noisy      (noisy),
    .clean      (clean),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the level seen by the counter is the input delayed by the synchroniser
  // plus the last register; clean flips after DLY ticks during which that level held and differed.
  logic          m_dl [CH][SS+1];
  int            m_ticks [CH];
  logic [CH-1:0] m_clean, m_rise, m_fall;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      for (int j = 0; j <= SS; j++) m_dl[i][j] = INIT[i];
      m_ticks[i] = 0;
    end
    m_clean = INIT;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] n, input logic t);
    logic s, l;
    for (int i = 0; i < CH; i++) begin
      s = m_dl[i][SS-1];
      l = m_dl[i][SS];
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (s != l || l == m_clean[i]) begin
        m_ticks[i] = 0;
      end else if (t) begin
        m_ticks[i]++;
        if (m_ticks[i] == DLY) begin
          m_clean[i] = l;
          m_ticks[i] = 0;
          m_rise[i]  = l;
          m_fall[i]  = !l;
        end
      end
      for (int j = SS; j > 0; j--) m_dl[i][j] = m_dl[i][j-1];
      m_dl[i][0] = n[i];
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (reset) model_reset();
    else       model_step(noisy, tick);
    check("model_clean", 32'(clean), 32'(m_clean));
    check("model_rise",  32'(rise),  32'(m_rise));
    check("model_fall",  32'(fall),  32'(m_fall));
    check("model_any",   32'(any_change), 32'(|(m_rise | m_fall)));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic       seen;
  logic [3:0] pulses;

  initial begin
    model_reset();

    // Reset with noisy=0101, then release: clean rises on the 7th edge after release.
    cycles(3);
    check("rst_clean", 32'(clean), 32'h0);
    check("rst_pulses", 32'({rise, fall, any_change}), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 6) check("rel_clean_e6", 32'(clean), 32'h0);
      if (k == 7) begin
        check("rel_clean_e7", 32'(clean), 32'h5);
        check("rel_rise_e7", 32'(rise), 32'h5);
      end
      if (k == 8) check("rel_rise_e8", 32'(rise), 32'h0);
    end

    // Single step on channel 0.
    noisy = 4'b0000;
    cycles(12);
    check("settle_low", 32'(clean), 32'h0);
    noisy = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 6) check("step0_e6", 32'(clean[0]), 32'h0);
      if (k == 7) begin
        check("step0_e7", 32'(clean[0]), 32'h1);
        check("step0_rise", 32'(rise[0]), 32'h1);
        check("step0_fall", 32'(fall[0]), 32'h0);
      end
      if (k == 8) check("step0_rise_off", 32'(rise[0]), 32'h0);
    end

    // Channel 1 toggles every 3 cycles, then is held high.
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      noisy[1] = ((k / 3) % 2 == 0);
      @(negedge clock);
      seen |= clean[1];
    end
    check("toggle_quiet", 32'(seen), 32'h0);
    noisy[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 6) check("toggle_e6", 32'(clean[1]), 32'h0);
      if (k == 7) check("toggle_e7", 32'(rise[1]), 32'h1);
    end

    // Two-cycle glitch on channel 2 must not propagate; a real step afterwards still takes 7 edges.
    pulses = '0;
    noisy[2] = 1'b1;
    cycles(2);
    noisy[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      pulses |= {clean[2], rise[2], fall[2], any_change};
    end
    check("glitch_quiet", 32'(pulses), 32'h0);
    noisy[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 6) check("post_glitch_e6", 32'(clean[2]), 32'h0);
      if (k == 7) check("post_glitch_e7", 32'(clean[2]), 32'h1);
    end

    // Tick every 10th cycle: channel 3 changes on the 4th tick after last settles (edge 40).
    noisy[3] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick = (k % 10 == 0);
      @(negedge clock);
      if (k == 39) check("tick_e39", 32'(clean[3]), 32'h0);
      if (k == 40) begin
        check("tick_e40", 32'(clean[3]), 32'h1);
        check("tick_rise", 32'(rise[3]), 32'h1);
      end
    end
    tick = 1'b1;

    // Simultaneous rise on channel 2 and fall on channel 3.
    noisy = 4'b1000;
    cycles(12);
    check("pre_sim_clean", 32'(clean), 32'h8);
    noisy = 4'b0100;
    cycles(7);
    check("sim_rise", 32'(rise), 32'h4);
    check("sim_fall", 32'(fall), 32'h8);
    check("sim_any", 32'(any_change), 32'h1);

    // Async reset mid-count (counter at 2 after edge 5) abandons the count without a pulse.
    noisy = 4'b1000;
    cycles(5);
    reset = 1'b1;
    #1;
    check("async_clean", 32'(clean), 32'(INIT));
    check("async_pulses", 32'({rise, fall, any_change}), 32'h0);
    noisy = 4'b0000;
    cycles(2);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      seen |= any_change;
    end
    check("post_rst_quiet", 32'(seen), 32'h0);

    // Randomized phase: sparse per-channel flips, tick mostly high, occasional reset.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 9) == 0) noisy[i] = ~noisy[i];
      end
      tick = (k < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      else if (reset && $urandom_range(0, 1) == 0) reset = 1'b0;
      @(negedge clock);
    end
    reset = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
